// File: rtl/riscv_branch_pkg.sv
// Shared constants for the execute-stage branch resolution slice.
// Holds funct3 codes, FSM state encoding and datapath defaults.
package riscv_branch_pkg;

  localparam int XLEN_DEFAULT = 64;
  localparam int FLUSH_DEFAULT = 2;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_FLUSH = 1'b1
  } bru_state_e;

  // funct3 values 010/011 are unassigned for conditional branches
  function automatic logic f3_reserved(
    input logic [2:0] f3
  );
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_cmp_64.sv
// Combinational 64-bit comparator feeding branch resolution.
// Signed order derives from the sign bits plus unsigned magnitude.
module branch_cmp_64
  import riscv_branch_pkg::*;
#(
  parameter int W = XLEN_DEFAULT
) (
  input  logic [W-1:0] rs1,
  input  logic [W-1:0] rs2,
  output logic         eq,
  output logic         lt_s,
  output logic         lt_u
);

  logic sign_diff;

  // equality, unsigned magnitude, and signed order
  always_comb begin
    eq        = (rs1 == rs2);
    lt_u      = (rs1 < rs2);
    sign_diff = rs1[W-1] ^ rs2[W-1];
    lt_s      = sign_diff ? rs1[W-1] : lt_u;
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Branch/jump resolution with registered redirect and flush FSM.
// Optional counters enabled by defining BRANCH_STATS_EN.
module branch_resolve_unit
  import riscv_branch_pkg::*;
#(
  parameter int XLEN         = XLEN_DEFAULT,
  parameter int FLUSH_CYCLES = FLUSH_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic            stall,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic            pred_taken,
  output logic            out_valid,
  output logic            taken,
  output logic            redirect,
  output logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] link_data,
  output logic            flush,
  output logic            illegal,
  output logic            busy
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]     stat_branches,
  output logic [31:0]     stat_mispred
`endif
);

  localparam int CNT_W =
    (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam logic [XLEN-1:0] FOUR = XLEN'(4);
  localparam logic [CNT_W-1:0] CNT_LOAD =
    CNT_W'(FLUSH_CYCLES - 1);

  logic            eq;
  logic            lt_s;
  logic            lt_u;

  branch_cmp_64 #(
    .W (XLEN)
  ) u_cmp (
    .rs1  (rs1),
    .rs2  (rs2),
    .eq   (eq),
    .lt_s (lt_s),
    .lt_u (lt_u)
  );

  bru_state_e      state_q;
  bru_state_e      state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  logic            out_valid_q;
  logic            out_valid_d;
  logic            taken_q;
  logic            taken_d;
  logic            redirect_q;
  logic            redirect_d;
  logic            illegal_q;
  logic            illegal_d;
  logic [XLEN-1:0] redirect_pc_q;
  logic [XLEN-1:0] redirect_pc_d;
  logic [XLEN-1:0] link_data_q;
  logic [XLEN-1:0] link_data_d;

  logic            cond;
  logic            op_taken;
  logic            op_illegal;
  logic            op_mispred;
  logic [XLEN-1:0] pc_plus4;
  logic [XLEN-1:0] pc_target;
  logic [XLEN-1:0] jalr_sum;
  logic [XLEN-1:0] op_target;
  logic [XLEN-1:0] op_link;
  logic            capture;

  // branch condition selected by funct3
  always_comb begin
    cond = 1'b0;
    unique case (funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

  // outcome, target, link value and mispredict for the op on the inputs
  always_comb begin
    pc_plus4   = pc + FOUR;
    pc_target  = pc + imm;
    jalr_sum   = rs1 + imm;
    op_taken   = 1'b0;
    op_illegal = 1'b0;
    op_mispred = 1'b0;
    op_target  = pc_target;
    op_link    = '0;
    unique case (1'b1)
      is_branch: begin
        op_taken   = cond;
        op_illegal = f3_reserved(funct3);
        op_mispred = cond != pred_taken;
      end
      is_jal: begin
        op_taken   = 1'b1;
        op_mispred = !pred_taken;
        op_link    = pc_plus4;
      end
      is_jalr: begin
        op_taken   = 1'b1;
        op_mispred = 1'b1;
        op_target  = {jalr_sum[XLEN-1:1], 1'b0};
        op_link    = pc_plus4;
      end
      default: begin
        op_taken = 1'b0;
      end
    endcase
  end

  assign capture = in_valid && !stall && (state_q == ST_IDLE);

  // next-state, flush countdown and result capture
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    out_valid_d   = 1'b0;
    redirect_d    = 1'b0;
    illegal_d     = 1'b0;
    taken_d       = taken_q;
    redirect_pc_d = redirect_pc_q;
    link_data_d   = link_data_q;
    unique case (state_q)
      ST_IDLE: begin
        if (capture) begin
          out_valid_d   = 1'b1;
          taken_d       = op_taken;
          illegal_d     = op_illegal;
          redirect_d    = op_mispred;
          redirect_pc_d = op_taken ? op_target : pc_plus4;
          link_data_d   = op_link;
          if (op_mispred) begin
            state_d = ST_FLUSH;
            cnt_d   = CNT_LOAD;
          end
        end
      end
      ST_FLUSH: begin
        if (cnt_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      out_valid_q   <= 1'b0;
      taken_q       <= 1'b0;
      redirect_q    <= 1'b0;
      illegal_q     <= 1'b0;
      redirect_pc_q <= '0;
      link_data_q   <= '0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      out_valid_q   <= out_valid_d;
      taken_q       <= taken_d;
      redirect_q    <= redirect_d;
      illegal_q     <= illegal_d;
      redirect_pc_q <= redirect_pc_d;
      link_data_q   <= link_data_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign taken       = taken_q;
  assign redirect    = redirect_q;
  assign illegal     = illegal_q;
  assign redirect_pc = redirect_pc_q;
  assign link_data   = link_data_q;
  assign flush       = (state_q == ST_FLUSH);
  assign busy        = (state_q != ST_IDLE);

`ifdef BRANCH_STATS_EN
  logic [31:0] stat_br_q;
  logic [31:0] stat_br_d;
  logic [31:0] stat_mp_q;
  logic [31:0] stat_mp_d;

  // saturating counts, stepped alongside the pulse they count
  always_comb begin
    stat_br_d = stat_br_q;
    stat_mp_d = stat_mp_q;
    if (out_valid_d && (stat_br_q != '1)) begin
      stat_br_d = stat_br_q + 32'd1;
    end
    if (redirect_d && (stat_mp_q != '1)) begin
      stat_mp_d = stat_mp_q + 32'd1;
    end
  end

  // statistics registers
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_br_q <= '0;
      stat_mp_q <= '0;
    end else begin
      stat_br_q <= stat_br_d;
      stat_mp_q <= stat_mp_d;
    end
  end

  assign stat_branches = stat_br_q;
  assign stat_mispred  = stat_mp_q;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
// Stats checks compile only when BRANCH_STATS_EN is defined.
module tb_branch_resolve_unit;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        stall;
  logic        is_branch;
  logic        is_jal;
  logic        is_jalr;
  logic [2:0]  funct3;
  logic [63:0] rs1;
  logic [63:0] rs2;
  logic [63:0] pc;
  logic [63:0] imm;
  logic        pred_taken;
  logic        out_valid;
  logic        taken;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic [63:0] link_data;
  logic        flush;
  logic        illegal;
  logic        busy;
`ifdef BRANCH_STATS_EN
  logic [31:0] stat_branches;
  logic [31:0] stat_mispred;
`endif

  int checks;
  int failures;

  branch_resolve_unit #(
    .XLEN         (64),
    .FLUSH_CYCLES (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .stall       (stall),
    .is_branch   (is_branch),
    .is_jal      (is_jal),
    .is_jalr     (is_jalr),
    .funct3      (funct3),
    .rs1         (rs1),
    .rs2         (rs2),
    .pc          (pc),
    .imm         (imm),
    .pred_taken  (pred_taken),
    .out_valid   (out_valid),
    .taken       (taken),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .link_data   (link_data),
    .flush       (flush),
    .illegal     (illegal),
    .busy        (busy)
`ifdef BRANCH_STATS_EN
    ,
    .stat_branches (stat_branches),
    .stat_mispred  (stat_mispred)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_op(
    input logic        br,
    input logic        j,
    input logic        jr,
    input logic [2:0]  f3,
    input logic [63:0] a,
    input logic [63:0] b,
    input logic [63:0] p,
    input logic [63:0] i,
    input logic        pr
  );
    in_valid   = 1'b1;
    is_branch  = br;
    is_jal     = j;
    is_jalr    = jr;
    funct3     = f3;
    rs1        = a;
    rs2        = b;
    pc         = p;
    imm        = i;
    pred_taken = pr;
  endtask

  task automatic idle_in();
    in_valid  = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    is_jalr   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, taken, redirect, flush, illegal, busy} !== 6'b0) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=000000",
               {out_valid, taken, redirect, flush, illegal, busy});
    end
    checks++;
    if (redirect_pc !== 64'h0 || link_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_data got pc=%h link=%h want 0", redirect_pc, link_data);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_mispredict_blt();
    set_op(1, 0, 0, 3'b100, -64'd15, 64'd16, 64'h100, 64'h40, 0);
    tick();
    idle_in();
    checks++;
    if ({out_valid, taken, redirect, flush, busy} !== 5'b11111) begin
      failures++;
      $display("FAIL blt_n1 got=%b want=11111",
               {out_valid, taken, redirect, flush, busy});
    end
    checks++;
    if (redirect_pc !== 64'h140) begin
      failures++;
      $display("FAIL blt_pc got=%h want=140", redirect_pc);
    end
    tick();
    checks++;
    if ({out_valid, redirect, flush, busy} !== 4'b0011) begin
      failures++;
      $display("FAIL blt_n2 got=%b want=0011",
               {out_valid, redirect, flush, busy});
    end
    tick();
    checks++;
    if ({flush, busy} !== 2'b00) begin
      failures++;
      $display("FAIL blt_n3 got=%b want=00", {flush, busy});
    end
  endtask

  task automatic test_back_to_back();
    set_op(1, 0, 0, 3'b101, 64'd32, -64'd16, 64'h300, 64'h8, 1);
    tick();
    checks++;
    if ({out_valid, taken, redirect, flush} !== 4'b1100 ||
        redirect_pc !== 64'h308) begin
      failures++;
      $display("FAIL bge got=%b pc=%h want=1100 pc=308",
               {out_valid, taken, redirect, flush}, redirect_pc);
    end
    set_op(1, 0, 0, 3'b000, -64'd15, -64'd15, 64'h304, 64'h20, 1);
    tick();
    idle_in();
    checks++;
    if ({out_valid, taken, redirect} !== 3'b110 ||
        redirect_pc !== 64'h324) begin
      failures++;
      $display("FAIL beq_b2b got=%b pc=%h want=110 pc=324",
               {out_valid, taken, redirect}, redirect_pc);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || taken !== 1'b1) begin
      failures++;
      $display("FAIL b2b_hold got v=%b t=%b want v=0 t=1", out_valid, taken);
    end
  endtask

  task automatic test_signed_unsigned();
    set_op(1, 0, 0, 3'b110, 64'h0, 64'h8000000000000000,
           64'h500, 64'h10, 1);
    tick();
    checks++;
    if ({out_valid, taken, redirect} !== 3'b110) begin
      failures++;
      $display("FAIL bltu got=%b want=110", {out_valid, taken, redirect});
    end
    set_op(1, 0, 0, 3'b100, 64'h0, 64'h8000000000000000,
           64'h504, 64'h10, 1);
    tick();
    idle_in();
    checks++;
    if ({out_valid, taken, redirect} !== 3'b101 ||
        redirect_pc !== 64'h508) begin
      failures++;
      $display("FAIL blt_sgn got=%b pc=%h want=101 pc=508",
               {out_valid, taken, redirect}, redirect_pc);
    end
    tick();
    tick();
  endtask

  task automatic test_jumps();
    set_op(0, 0, 1, 3'b000, 64'h1001, 64'h0, 64'h200, 64'h10, 1);
    tick();
    idle_in();
    checks++;
    if ({out_valid, taken, redirect} !== 3'b111 ||
        redirect_pc !== 64'h1010 || link_data !== 64'h204) begin
      failures++;
      $display("FAIL jalr got=%b pc=%h link=%h want=111 pc=1010 link=204",
               {out_valid, taken, redirect}, redirect_pc, link_data);
    end
    tick();
    tick();
    set_op(0, 1, 0, 3'b000, 64'h0, 64'h0, 64'h400, -64'd8, 1);
    tick();
    idle_in();
    checks++;
    if ({out_valid, taken, redirect, flush} !== 4'b1100 ||
        redirect_pc !== 64'h3f8 || link_data !== 64'h404) begin
      failures++;
      $display("FAIL jal got=%b pc=%h link=%h want=1100 pc=3f8 link=404",
               {out_valid, taken, redirect, flush}, redirect_pc, link_data);
    end
    tick();
  endtask

  task automatic test_reset_mid_flush();
    set_op(1, 0, 0, 3'b001, 64'd5, 64'd6, 64'h600, 64'h40, 0);
    tick();
    idle_in();
    checks++;
    if ({redirect, flush} !== 2'b11) begin
      failures++;
      $display("FAIL rmf_pre got=%b want=11", {redirect, flush});
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({out_valid, taken, redirect, flush, illegal, busy} !== 6'b0 ||
        redirect_pc !== 64'h0 || link_data !== 64'h0) begin
      failures++;
      $display("FAIL rmf_rst got=%b pc=%h link=%h want all 0",
               {out_valid, taken, redirect, flush, illegal, busy},
               redirect_pc, link_data);
    end
    rst = 1'b0;
    tick();
    checks++;
    if ({flush, busy} !== 2'b00) begin
      failures++;
      $display("FAIL rmf_post got=%b want=00", {flush, busy});
    end
  endtask

  task automatic test_flush_ignore();
    set_op(1, 0, 0, 3'b000, 64'd1, 64'd2, 64'h700, 64'h40, 1);
    tick();
    checks++;
    if ({out_valid, taken, redirect} !== 3'b101 ||
        redirect_pc !== 64'h704) begin
      failures++;
      $display("FAIL fi_mp got=%b pc=%h want=101 pc=704",
               {out_valid, taken, redirect}, redirect_pc);
    end
    set_op(1, 0, 0, 3'b000, 64'd3, 64'd3, 64'h800, 64'h20, 1);
    tick();
    checks++;
    if ({out_valid, flush} !== 2'b01) begin
      failures++;
      $display("FAIL fi_c2 got=%b want=01", {out_valid, flush});
    end
    tick();
    checks++;
    if ({out_valid, flush, busy} !== 3'b000) begin
      failures++;
      $display("FAIL fi_c3 got=%b want=000", {out_valid, flush, busy});
    end
    tick();
    idle_in();
    checks++;
    if ({out_valid, taken, redirect} !== 3'b110 ||
        redirect_pc !== 64'h820) begin
      failures++;
      $display("FAIL fi_c4 got=%b pc=%h want=110 pc=820",
               {out_valid, taken, redirect}, redirect_pc);
    end
    tick();
  endtask

  task automatic test_illegal_noclass();
    set_op(1, 0, 0, 3'b010, 64'd1, 64'd1, 64'h900, 64'h40, 0);
    tick();
    checks++;
    if ({out_valid, taken, redirect, illegal} !== 4'b1001) begin
      failures++;
      $display("FAIL illegal got=%b want=1001",
               {out_valid, taken, redirect, illegal});
    end
    set_op(0, 0, 0, 3'b000, 64'd1, 64'd1, 64'ha00, 64'h40, 0);
    tick();
    idle_in();
    checks++;
    if ({out_valid, taken, redirect, illegal} !== 4'b1000 ||
        link_data !== 64'h0) begin
      failures++;
      $display("FAIL noclass got=%b link=%h want=1000 link=0",
               {out_valid, taken, redirect, illegal}, link_data);
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    set_op(0, 0, 1, 3'b000, 64'h40, 64'h0, 64'hb00, 64'h0, 0);
    tick();
    idle_in();
    stall = 1'b0;
    checks++;
    if ({out_valid, redirect, busy} !== 3'b000) begin
      failures++;
      $display("FAIL stall got=%b want=000", {out_valid, redirect, busy});
    end
  endtask

`ifdef BRANCH_STATS_EN
  task automatic test_stats();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_op(1, 0, 0, 3'b000, 64'd4, 64'd4, 64'h10, 64'h8, 1);
    tick();
    set_op(1, 0, 0, 3'b001, 64'd4, 64'd4, 64'h14, 64'h8, 1);
    tick();
    idle_in();
    tick();
    tick();
    set_op(1, 0, 0, 3'b100, -64'd1, 64'd0, 64'h18, 64'h8, 1);
    tick();
    set_op(0, 1, 0, 3'b000, 64'd0, 64'd0, 64'h1c, 64'h8, 0);
    tick();
    idle_in();
    tick();
    tick();
    set_op(0, 0, 0, 3'b000, 64'd0, 64'd0, 64'h20, 64'h8, 0);
    tick();
    idle_in();
    tick();
    checks++;
    if (stat_branches !== 32'd5 || stat_mispred !== 32'd2) begin
      failures++;
      $display("FAIL stats got br=%0d mp=%0d want br=5 mp=2",
               stat_branches, stat_mispred);
    end
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    stall    = 1'b0;
    funct3   = 3'b000;
    rs1      = '0;
    rs2      = '0;
    pc       = '0;
    imm      = '0;
    pred_taken = 1'b0;
    idle_in();
    @(negedge clk);
    test_reset();
    test_mispredict_blt();
    test_back_to_back();
    test_signed_unsigned();
    test_jumps();
    test_reset_mid_flush();
    test_flush_ignore();
    test_illegal_noclass();
    test_stall();
`ifdef BRANCH_STATS_EN
    test_stats();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/branch_resolve_unit.md
# branch_resolve_unit

Execute-stage branch resolution unit for the 64-bit pipelined RISC-V core. Sits directly downstream of the signed/unsigned 64-bit comparator. It evaluates BEQ/BNE/BLT/BGE/BLTU/BGEU/JAL/JALR, computes the target and link value, and checks the decode-stage prediction. On a mispredict it issues a registered one-cycle redirect and a multi-cycle flush to the front end.

## Interface
- XLEN, 64, datapath width
- FLUSH_CYCLES, 2, cycles flush stays high after a redirect (≥1)
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  control-flow op presented
- stall  in  1  downstream hold; blocks input capture
- is_branch / is_jal / is_jalr  in  1 each  op class, one-hot or all zero
- funct3  in  3  branch condition
- rs1, rs2  in  XLEN  operands (two's complement)
- pc, imm  in  XLEN  instruction PC, sign-extended immediate
- pred_taken  in  1  decode prediction
- out_valid  out  1  registered result valid
- taken  out  1  resolved outcome
- redirect  out  1  one-cycle pulse, fetch must load redirect_pc
- redirect_pc  out  XLEN  corrected fetch address
- link_data  out  XLEN  pc+4 for JAL/JALR, else 0
- flush  out  1  squash wrong-path IF/ID
- illegal  out  1  funct3 010/011 on a branch
- busy  out  1  FSM not IDLE

## Operation
- Conditions: 000 rs1==rs2; 001 !=; 100 signed <; 101 signed ≥; 110 unsigned <; 111 unsigned ≥; 010/011 → not taken, illegal=1.
- JAL/JALR are always taken. Target is pc+imm for branch/JAL. JALR target is (rs1+imm) with bit 0 cleared. Adds wrap modulo 2^XLEN.
- redirect_pc: target if taken, else pc+4.
- Mispredict: branch with taken≠pred_taken; JAL with pred_taken=0; JALR always.
- Capture: in_valid & !stall & state==IDLE.
- FSM states:
  - IDLE. On a capture with mispredict → FLUSH, with redirect pulsed and flush counter loaded to FLUSH_CYCLES−1.
  - FLUSH. flush=1. Inputs are ignored and out_valid=0. Counter decrements each cycle; → IDLE when it is 0.
- Stall does not pause FLUSH.
- Reset: every output 0, state IDLE, counter 0. Reset mid-FLUSH aborts the sequence and leaves no residual flush.
- in_valid with no op class set: out_valid=1, taken=0, no redirect.

## Timing
- Latency 1. Capture at edge N → out_valid, taken, redirect, redirect_pc, link_data and illegal are valid during cycle N+1.
- out_valid, redirect and illegal are single-cycle pulses per capture. Data outputs hold their last value.
- flush is high in cycles N+1 … N+FLUSH_CYCLES inclusive.
- Throughput: one op per cycle when there is no mispredict. After a mispredict, the next capture happens no earlier than cycle N+FLUSH_CYCLES+1.
- Stall with in_valid: nothing captured, out_valid=0 next cycle.

## Configuration
- BRANCH_STATS_EN defined:
  - Adds outputs stat_branches (32) and stat_mispred (32).
  - stat_branches counts out_valid pulses; stat_mispred counts redirect pulses.
  - Both saturate at 2^32−1 and clear on rst.
- Not defined: ports and counters are absent. Functional behaviour is otherwise identical.

## Structure
- Package riscv_branch_pkg holds:
  - funct3 constants: F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU.
  - state encoding: ST_IDLE, ST_FLUSH.
  - XLEN default.
- Sub-module branch_cmp_64 is purely combinational. Outputs eq, lt_s, lt_u from rs1/rs2. Signed via sign-bit compare plus magnitude. Instantiated once.
- Top holds the condition mux, target adders, mispredict logic, output registers, FSM/counter and optional stats.

## Test plan
- BLT rs1=−15 rs2=16 pc=0x100 imm=0x40 pred_taken=0 → cycle N+1: taken=1, redirect=1, redirect_pc=0x140. flush high for exactly 2 cycles; busy high for the same 2 cycles.
- BGE rs1=32 rs2=−16, pred=1 → taken=1, no redirect, out_valid pulse. Back-to-back BEQ rs1=rs2=−15, pred=1, accepted the next cycle → taken=1.
- BLTU rs1=0 rs2=0x8000000000000000 → taken=1. BLT on the same operands → taken=0 (signed: 0 > −2^63).
- JALR rs1=0x1001 imm=0x10 pc=0x200 → redirect_pc=0x1010, link_data=0x204, redirect=1 regardless of pred_taken.
- Mispredict, then rst asserted in flush cycle 1 → next cycle all outputs 0, busy=0. in_valid during flush is ignored, with no out_valid.
- Branch funct3=010 → illegal=1, taken=0. With BRANCH_STATS_EN: after 5 ops including 2 mispredicts → stat_branches=5, stat_mispred=2.
